// File: rtl/mem_pkg.sv
// Shared sizing defaults and FSM state type for the SPRAM initiator port.
package mem_pkg;
  localparam int unsigned ASZ_DEF = 16;
  localparam int unsigned DSZ_DEF = 32;
  localparam int unsigned NLANE   = DSZ_DEF / 8;
  localparam int unsigned LW      = $clog2(NLANE);

  typedef enum logic [1:0] {IDLE, RDATA, RMW, WACK} port_st_t;
endpackage

// File: rtl/spram_lane.sv
// Byte-lane helpers: zero-extendable byte extract and single-lane merge into a word.
module spram_lane
  import mem_pkg::*;
#(
  parameter int unsigned DSZ = DSZ_DEF
) (
  input  logic [DSZ-1:0] vo_i,
  input  logic [LW-1:0]  lane_i,
  input  logic [7:0]     byte_i,
  output logic [7:0]     byte_o,
  output logic [DSZ-1:0] word_o
);
  always_comb begin
    byte_o                 = vo_i[8*lane_i +: 8];
    word_o                 = vo_i;
    word_o[8*lane_i +: 8]  = byte_i;
  end
endmodule

// File: rtl/spram_port.sv
// Initiator-side SPRAM controller: word/byte reads and writes over valid/ready.
// MEM_BYTE_EN enables byte access (byte stores via read-modify-write).
module spram_port
  import mem_pkg::*;
#(
  parameter int unsigned ASZ = ASZ_DEF,
  parameter int unsigned DSZ = DSZ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_byte,
  input  logic [ASZ+1:0]   req_addr,
  input  logic [DSZ-1:0]   req_wdata,
  output logic             rsp_valid,
  output logic [DSZ-1:0]   rsp_rdata,
  output logic             mem_we,
  output logic [ASZ-1:0]   mem_a,
  output logic [DSZ-1:0]   mem_vi,
  input  logic [DSZ-1:0]   mem_vo
);
  port_st_t       state_q, state_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic           accept;

`ifdef MEM_BYTE_EN
  logic [LW-1:0]  lane_q, lane_d;
  logic [7:0]     wbyte_q, wbyte_d;
  logic           byte_q, byte_d;
  logic [7:0]     rd_byte;
  logic [DSZ-1:0] merged;

  spram_lane #(
    .DSZ (DSZ)
  ) u_lane (
    .vo_i   (mem_vo),
    .lane_i (lane_q),
    .byte_i (wbyte_q),
    .byte_o (rd_byte),
    .word_o (merged)
  );
`else
  logic unused_byte;
  assign unused_byte = ^{req_byte, req_addr[LW-1:0]};
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
`ifdef MEM_BYTE_EN
    lane_d    = lane_q;
    wbyte_d   = wbyte_q;
    byte_d    = byte_q;
`endif
    req_ready = (state_q == IDLE) && !rst;
    accept    = req_valid && req_ready;
    mem_we    = 1'b0;
    mem_a     = addr_q;
    mem_vi    = req_wdata;
    rsp_valid = 1'b0;
    rsp_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Address goes to the SPRAM in the accept cycle; word accesses align down.
          mem_a  = req_addr[ASZ+LW-1:LW];
          addr_d = req_addr[ASZ+LW-1:LW];
`ifdef MEM_BYTE_EN
          lane_d  = req_addr[LW-1:0];
          wbyte_d = req_wdata[7:0];
          byte_d  = req_byte;
          if (req_we && !req_byte) begin
            mem_we  = 1'b1;
            state_d = WACK;
          end else if (req_we) begin
            state_d = RMW;
          end else begin
            state_d = RDATA;
          end
`else
          if (req_we) begin
            mem_we  = 1'b1;
            state_d = WACK;
          end else begin
            state_d = RDATA;
          end
`endif
        end
      end
      RDATA: begin
        rsp_valid = 1'b1;
`ifdef MEM_BYTE_EN
        rsp_rdata = byte_q ? DSZ'(rd_byte) : mem_vo;
`else
        rsp_rdata = mem_vo;
`endif
        state_d   = IDLE;
      end
`ifdef MEM_BYTE_EN
      RMW: begin
        mem_we  = 1'b1;
        mem_vi  = merged;
        state_d = WACK;
      end
`endif
      WACK: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must cancel an in-flight merged write and any response.
    if (rst) begin
      mem_we    = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
`ifdef MEM_BYTE_EN
      lane_q  <= '0;
      wbyte_q <= '0;
      byte_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef MEM_BYTE_EN
      lane_q  <= lane_d;
      wbyte_q <= wbyte_d;
      byte_q  <= byte_d;
`endif
    end
  end
endmodule

// File: tb/tb_spram_port.sv
// Self-checking bench for spram_port with a behavioural SPRAM and a word-array reference model.
module tb_spram_port;
  localparam int unsigned ASZ = 16;
  localparam int unsigned DSZ = 32;
`ifdef MEM_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we, req_byte;
  logic [ASZ+1:0]   req_addr;
  logic [DSZ-1:0]   req_wdata;
  logic             rsp_valid;
  logic [DSZ-1:0]   rsp_rdata;
  logic             mem_we;
  logic [ASZ-1:0]   mem_a;
  logic [DSZ-1:0]   mem_vi, mem_vo;

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [int];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural SPRAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_vi;
    mem_vo <= mem[mem_a];
  end

  spram_port #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_vi    (mem_vi),
    .mem_vo    (mem_vo)
  );

  function automatic logic [31:0] model_op(input bit we, input bit byt, input logic [17:0] addr,
                                           input logic [31:0] wd);
    int w;
    int sh;
    bit b;
    logic [31:0] cur;
    w   = int'(addr >> 2);
    sh  = 8 * int'(addr[1:0]);
    b   = byt && BYTE_EN;
    cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    if (we) begin
      if (b) ref_mem[w] = (cur & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
      else   ref_mem[w] = wd;
      return 32'h0;
    end
    return b ? ((cur >> sh) & 32'hFF) : cur;
  endfunction

  task automatic do_op(input bit we, input bit byt, input logic [17:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output int cyc, output logic acc_we,
                       output logic [15:0] acc_a, output logic [31:0] acc_vi,
                       output logic late_we, output logic [31:0] late_vi);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    acc_we = mem_we; acc_a = mem_a; acc_vi = mem_vi;
    cyc = 1; late_we = 1'b0; late_vi = 32'h0; rdata = 32'hxxxxxxxx;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      cyc++;
      if (mem_we) begin late_we = 1'b1; late_vi = mem_vi; end
      if (rsp_valid) begin rdata = rsp_rdata; break; end
    end
    if (n == 8) begin
      n_tests++; n_fail++;
      $display("FAIL op_timeout addr=%h got=no rsp_valid exp=rsp_valid within 8 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 18'h400; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_word_write();
    logic [31:0] rd, vi, lvi, e; int cyc; logic aw, lw; logic [15:0] a;
    e = model_op(1'b1, 1'b0, 18'h400, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 18'h400, 32'hDEADBEEF, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (aw !== 1'b1) begin n_fail++; $display("FAIL ww_we got=%b exp=1", aw); end
    n_tests++; if (a !== 16'h100) begin n_fail++; $display("FAIL ww_addr got=%h exp=0100", a); end
    n_tests++; if (vi !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ww_vi got=%h exp=deadbeef", vi); end
    n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL ww_cycles got=%0d exp=2", cyc); end
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL ww_ack_rdata got=%h exp=%h", rd, e); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ww_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_word_read();
    logic [31:0] rd, vi, lvi, e; int cyc; logic aw, lw; logic [15:0] a;
    e = model_op(1'b0, 1'b0, 18'h402, 32'h0);
    do_op(1'b0, 1'b0, 18'h402, 32'h0, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (aw !== 1'b0) begin n_fail++; $display("FAIL wr_we got=%b exp=0", aw); end
    n_tests++; if (a !== 16'h100) begin n_fail++; $display("FAIL wr_addr got=%h exp=0100", a); end
    n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL wr_cycles got=%0d exp=2", cyc); end
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL wr_data got=%h exp=%h", rd, e); end
  endtask

  task automatic test_byte_read();
    logic [31:0] rd, vi, lvi, e; int cyc; logic aw, lw; logic [15:0] a;
    logic [17:0] ad [2];
    ad[0] = 18'h403; ad[1] = 18'h400;
    for (int i = 0; i < 2; i++) begin
      e = model_op(1'b0, 1'b1, ad[i], 32'h0);
      do_op(1'b0, 1'b1, ad[i], 32'h0, rd, cyc, aw, a, vi, lw, lvi);
      n_tests++; if (rd !== e) begin n_fail++; $display("FAIL br_data addr=%h got=%h exp=%h", ad[i], rd, e); end
      n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL br_cycles got=%0d exp=2", cyc); end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, vi, lvi, e; int cyc; logic aw, lw; logic [15:0] a;
    void'(model_op(1'b1, 1'b1, 18'h402, 32'hA5A5A55A));
    do_op(1'b1, 1'b1, 18'h402, 32'hA5A5A55A, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (aw !== !BYTE_EN) begin n_fail++; $display("FAIL bw_accept_we got=%b exp=%b", aw, !BYTE_EN); end
    n_tests++; if (lw !== BYTE_EN) begin n_fail++; $display("FAIL bw_rmw_we got=%b exp=%b", lw, BYTE_EN); end
    e = BYTE_EN ? ref_mem[32'h100] : 32'h0;
    n_tests++; if (lvi !== e) begin n_fail++; $display("FAIL bw_rmw_vi got=%h exp=%h", lvi, e); end
    n_tests++; if (cyc != (BYTE_EN ? 3 : 2)) begin n_fail++; $display("FAIL bw_cycles got=%0d exp=%0d", cyc, BYTE_EN ? 3 : 2); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL bw_ack_rdata got=%h exp=0", rd); end
    e = model_op(1'b0, 1'b0, 18'h400, 32'h0);
    do_op(1'b0, 1'b0, 18'h400, 32'h0, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL bw_readback got=%h exp=%h", rd, e); end
  endtask

  task automatic test_back_to_back();
    bit we [4]; bit byt [4]; logic [17:0] ad [4]; logic [31:0] wd [4];
    logic [31:0] expq [$];
    int idx, got, cyc;
    bit acc_prev;
    we[0] = 1; byt[0] = 0; ad[0] = 18'h404; wd[0] = 32'hCAFEF00D;
    we[1] = 0; byt[1] = 1; ad[1] = 18'h405; wd[1] = 32'h0;
    we[2] = 1; byt[2] = 1; ad[2] = 18'h406; wd[2] = 32'h00000077;
    we[3] = 0; byt[3] = 0; ad[3] = 18'h404; wd[3] = 32'h0;
    idx = 0; got = 0; cyc = 0; acc_prev = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we[0]; req_byte = byt[0]; req_addr = ad[0]; req_wdata = wd[0];
    while (got < 4 && cyc < 40) begin
      #1;
      if (acc_prev) begin
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready got=%b exp=0", req_ready); end
      end
      acc_prev = 0;
      if (rsp_valid && expq.size() > 0) begin
        n_tests++;
        if (rsp_rdata !== expq[0]) begin n_fail++; $display("FAIL b2b_rsp%0d got=%h exp=%h", got, rsp_rdata, expq[0]); end
        void'(expq.pop_front());
        got++;
      end
      if (req_ready && idx < 4) begin
        n_tests++;
        if (mem_a !== ad[idx][17:2]) begin n_fail++; $display("FAIL b2b_addr%0d got=%h exp=%h", idx, mem_a, ad[idx][17:2]); end
        expq.push_back(model_op(we[idx], byt[idx], ad[idx], wd[idx]));
        idx++;
        acc_prev = 1;
      end
      @(negedge clk);
      cyc++;
      if (idx < 4) begin
        req_we = we[idx]; req_byte = byt[idx]; req_addr = ad[idx]; req_wdata = wd[idx];
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL b2b_responses got=%0d exp=4", got); end
    n_tests++; if (idx != 4) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=4", idx); end
  endtask

  task automatic test_reset_rmw();
    logic [31:0] rd, vi, lvi, e; int cyc; logic aw, lw; logic [15:0] a;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 18'h401; req_wdata = 32'h11;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready got=%b exp=1", req_ready); end
    // Without byte support the store is a plain word write committed in the accept cycle.
    if (!BYTE_EN) void'(model_op(1'b1, 1'b1, 18'h401, 32'h11));
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rr_mem_we got=%b exp=0", mem_we); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rsp_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_idle got=%b exp=1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_rsp got=%b exp=0", rsp_valid); end
    e = model_op(1'b0, 1'b0, 18'h400, 32'h0);
    do_op(1'b0, 1'b0, 18'h400, 32'h0, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL rr_readback got=%h exp=%h", rd, e); end
  endtask

  task automatic test_top_address();
    logic [31:0] rd, vi, lvi, e; int cyc; logic aw, lw; logic [15:0] a;
    void'(model_op(1'b1, 1'b0, 18'h3FFFC, 32'h12345678));
    do_op(1'b1, 1'b0, 18'h3FFFC, 32'h12345678, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (a !== 16'hFFFF) begin n_fail++; $display("FAIL top_addr got=%h exp=ffff", a); end
    e = model_op(1'b0, 1'b0, 18'h3FFFF, 32'h0);
    do_op(1'b0, 1'b0, 18'h3FFFF, 32'h0, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL top_word got=%h exp=%h", rd, e); end
    e = model_op(1'b0, 1'b1, 18'h3FFFF, 32'h0);
    do_op(1'b0, 1'b1, 18'h3FFFF, 32'h0, rd, cyc, aw, a, vi, lw, lvi);
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL top_byte got=%h exp=%h", rd, e); end
  endtask

  task automatic test_random();
    logic [31:0] rd, vi, lvi, e, wd; int cyc; logic aw, lw; logic [15:0] a;
    logic [15:0] pool [4];
    logic [17:0] ad;
    bit we, byt;
    for (int i = 0; i < 4; i++) begin
      pool[i] = 16'($urandom);
      ad = {pool[i], 2'b00};
      wd = $urandom;
      void'(model_op(1'b1, 1'b0, ad, wd));
      do_op(1'b1, 1'b0, ad, wd, rd, cyc, aw, a, vi, lw, lvi);
    end
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom);
      byt = 1'($urandom);
      ad  = {pool[$urandom_range(0, 3)], 2'($urandom)};
      wd  = $urandom;
      e   = model_op(we, byt, ad, wd);
      do_op(we, byt, ad, wd, rd, cyc, aw, a, vi, lw, lvi);
      n_tests++; if (rd !== e) begin n_fail++; $display("FAIL rnd%0d_data we=%b byte=%b addr=%h got=%h exp=%h", i, we, byt, ad, rd, e); end
      n_tests++; if (cyc != ((we && byt && BYTE_EN) ? 3 : 2)) begin n_fail++; $display("FAIL rnd%0d_cycles got=%0d", i, cyc); end
      n_tests++; if (a !== ad[17:2]) begin n_fail++; $display("FAIL rnd%0d_addr got=%h exp=%h", i, a, ad[17:2]); end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_word_read();
    test_byte_read();
    test_byte_write();
    test_back_to_back();
    test_reset_rmw();
    test_top_address();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
